// File: rtl/conv_wgt_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : conv_wgt_ctrl
// Purpose  : Kernel-weight controller for the conv datapath. Host writes land
//            in a shadow bank. A commit request arms the controller, and the
//            next frame start copies the whole shadow bank into the active
//            bank in a single edge, so weights never change mid-frame. The
//            pixel-valid strobe is also delayed by the convolver latency.
// Ports    : clk, rst         - clock, synchronous active-high reset
//            i_sof            - frame-start pulse (vertical blanking)
//            i_dvld / o_dvld  - pixel valid in / delayed by CONV_LAT
//            i_wr_vld, o_wr_rdy, i_wr_addr, i_wr_data - tap write handshake
//            i_commit         - make shadow active at next frame start
//            o_flt_weight     - active bank, flat, tap k at [FW*(k+1)-1:FW*k]
//            o_pend           - write or commit outstanding
//            o_cmt_done       - one-cycle pulse when active bank updates
//            o_err            - one-cycle pulse after out-of-range write
// Revision : 1.0 - initial release
// ============================================================================
module conv_wgt_ctrl #(
    parameter int KERNEL_NUM = 25,
    parameter int FILTER_WTH = 8,
    parameter int AW         = 5,
    parameter int CONV_LAT   = 7
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             i_sof,
    input  logic                             i_dvld,
    input  logic                             i_wr_vld,
    output logic                             o_wr_rdy,
    input  logic [AW-1:0]                    i_wr_addr,
    input  logic [FILTER_WTH-1:0]            i_wr_data,
    input  logic                             i_commit,
    output logic [FILTER_WTH*KERNEL_NUM-1:0] o_flt_weight,
    output logic                             o_dvld,
    output logic                             o_pend,
    output logic                             o_cmt_done,
    output logic                             o_err
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_LOAD  = 2'd1;
    localparam logic [1:0] c_ARMED = 2'd2;

    logic [1:0]                        r_state;
    logic                              r_wr_rdy;
    logic                              r_pend;
    logic                              r_cmt_done;
    logic                              r_err;
    logic [FILTER_WTH*KERNEL_NUM-1:0]  r_shadow;
    logic [FILTER_WTH*KERNEL_NUM-1:0]  r_active;
    logic [CONV_LAT-1:0]               r_dvld_pipe;

    logic w_wr_acc;
    logic w_in_range;
    logic w_commit;

    assign w_wr_acc   = i_wr_vld && r_wr_rdy;
    assign w_in_range = ({{(32-AW){1'b0}}, i_wr_addr} < 32'(KERNEL_NUM));
    assign w_commit   = (r_state == c_ARMED) && i_sof;

    // Control FSM; all status outputs are registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_IDLE;
            r_wr_rdy   <= 1'b1;
            r_pend     <= 1'b0;
            r_cmt_done <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_cmt_done <= 1'b0;
            r_err      <= w_wr_acc && !w_in_range;
            case (r_state)
                c_IDLE, c_LOAD: begin
                    // Commit wins over a concurrent write; the write still
                    // lands in shadow and is part of this commit. A frame
                    // start in the same cycle is deliberately not honoured.
                    if (i_commit) begin
                        r_state  <= c_ARMED;
                        r_wr_rdy <= 1'b0;
                        r_pend   <= 1'b1;
                    end else if (w_wr_acc) begin
                        r_state  <= c_LOAD;
                        r_pend   <= 1'b1;
                    end
                end
                c_ARMED: begin
                    if (i_sof) begin
                        r_state    <= c_IDLE;
                        r_wr_rdy   <= 1'b1;
                        r_pend     <= 1'b0;
                        r_cmt_done <= 1'b1;
                    end
                end
                default: begin
                    r_state  <= c_IDLE;
                    r_wr_rdy <= 1'b1;
                    r_pend   <= 1'b0;
                end
            endcase
        end
    end

    // Shadow bank: out-of-range addresses match no tap, so data is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shadow <= '0;
        end else if (w_wr_acc) begin
            for (int k = 0; k < KERNEL_NUM; k++) begin
                if (i_wr_addr == AW'(k)) begin
                    r_shadow[k*FILTER_WTH +: FILTER_WTH] <= i_wr_data;
                end
            end
        end
    end

    // Active bank: whole-bank copy at the armed frame start.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_active <= '0;
        end else if (w_commit) begin
            r_active <= r_shadow;
        end
    end

    // Valid delay line, independent of the FSM.
    generate
        if (CONV_LAT == 1) begin : g_pipe_one
            always_ff @(posedge clk) begin
                if (rst) r_dvld_pipe <= '0;
                else     r_dvld_pipe <= i_dvld;
            end
        end else begin : g_pipe_multi
            always_ff @(posedge clk) begin
                if (rst) r_dvld_pipe <= '0;
                else     r_dvld_pipe <= {r_dvld_pipe[CONV_LAT-2:0], i_dvld};
            end
        end
    endgenerate

    assign o_wr_rdy     = r_wr_rdy;
    assign o_pend       = r_pend;
    assign o_cmt_done   = r_cmt_done;
    assign o_err        = r_err;
    assign o_flt_weight = r_active;
    assign o_dvld       = r_dvld_pipe[CONV_LAT-1];

endmodule
`default_nettype wire
